// File: rtl/pixel_stream_if.sv
// ---------------------------------------------------------------------------
// pixel_stream_if
// Purpose : one valid/ready pixel stream. A pixel moves from master to slave
//           on every clock edge where valid and ready are both high.
// Signals : valid - master has a pixel on data
//           ready - slave takes the pixel this cycle
//           data  - pixel value, PIX_W bits
// Modports: master drives valid/data and observes ready; slave the reverse.
// ---------------------------------------------------------------------------
interface pixel_stream_if #(
    parameter int PIX_W = 8
) ();
    logic             valid;
    logic             ready;
    logic [PIX_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pixel_stream_proc.sv
// ---------------------------------------------------------------------------
// pixel_stream_proc
// Purpose : streaming processor for one IMG_W x IMG_H raster frame. Modes:
//           00 bypass, 01 invert, 10 3x3 gaussian [1 2 1;2 4 2;1 2 1]/16
//           with valid windows only, 11 binary threshold against thresh_q.
// Ports   : i_clk        processing clock
//           i_rst        synchronous reset, active-high
//           i_start      level, sampled in IDLE, arms one frame
//           i_mode       processing mode, latched at frame start
//           i_thresh     threshold level, latched at frame start
//           s_in         input pixel stream (slave; ready = FIFO rd_en)
//           m_out        output pixel stream (master, one register stage)
//           o_busy       frame in progress
//           o_frame_done one-cycle pulse once the last output is accepted
// ---------------------------------------------------------------------------
module pixel_stream_proc #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [PIX_W-1:0] i_thresh,
    pixel_stream_if.slave    s_in,
    pixel_stream_if.master   m_out,
    output logic             o_busy,
    output logic             o_frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int SUM_W = PIX_W + 4;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Weighted 3x3 sum with rounding; the result never exceeds the largest
    // input, so no saturation is needed.
    function automatic logic [PIX_W-1:0] gauss3x3(
        input logic [PIX_W-1:0] t0, input logic [PIX_W-1:0] t1, input logic [PIX_W-1:0] t2,
        input logic [PIX_W-1:0] m0, input logic [PIX_W-1:0] m1, input logic [PIX_W-1:0] m2,
        input logic [PIX_W-1:0] b0, input logic [PIX_W-1:0] b1, input logic [PIX_W-1:0] b2);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(t0) + SUM_W'({t1, 1'b0}) + SUM_W'(t2)
            + SUM_W'({m0, 1'b0}) + SUM_W'({m1, 2'b00}) + SUM_W'({m2, 1'b0})
            + SUM_W'(b0) + SUM_W'({b1, 1'b0}) + SUM_W'(b2)
            + SUM_W'(4'd8);
        return PIX_W'(sum >> 4'd4);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_mode_q;
    logic [PIX_W-1:0]  r_thresh_q;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [PIX_W-1:0]  r_lb0 [0:IMG_W-1];   // previous line (row-1)
    logic [PIX_W-1:0]  r_lb1 [0:IMG_W-1];   // line before that (row-2)
    // Two older window columns: *0 = col-2, *1 = col-1. The incoming pixel
    // plus the two line-buffer taps form the third column.
    logic [PIX_W-1:0]  r_top0, r_top1, r_mid0, r_mid1, r_bot0, r_bot1;
    logic              r_valid_out;
    logic [PIX_W-1:0]  r_pixel_out;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_out_free;
    logic              w_ready_out;
    logic              w_flush_done;
    logic              w_xfer;
    logic              w_last_pix;
    logic              w_win_ok;
    logic              w_has_out;
    logic [PIX_W-1:0]  w_result;
    logic [PIX_W-1:0]  w_col_top;
    logic [PIX_W-1:0]  w_col_mid;

    // Output register is free when empty or being drained this cycle.
    assign w_out_free  = !r_valid_out || m_out.ready;
    assign w_xfer      = s_in.valid && w_ready_out;
    assign w_last_pix  = (r_col == COL_LAST) && (r_row == ROW_LAST);
    // col >= 2 keeps the whole window inside the current line.
    assign w_win_ok    = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_col_top   = r_lb1[r_col];
    assign w_col_mid   = r_lb0[r_col];

    assign s_in.ready    = w_ready_out;
    assign m_out.valid   = r_valid_out;
    assign m_out.data    = r_pixel_out;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_xfer && w_last_pix) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                if (w_out_free) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FLUSH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: input acceptance and flush completion.
    always_comb begin
        w_ready_out  = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            S_RUN:   w_ready_out  = w_out_free;
            S_FLUSH: w_flush_done = w_out_free;
            default: begin
                w_ready_out  = 1'b0;
                w_flush_done = 1'b0;
            end
        endcase
    end

    // Latch frame configuration when a frame is armed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode_q   <= 2'b00;
            r_thresh_q <= {PIX_W{1'b0}};
        end else if ((r_state == S_IDLE) && i_start) begin
            r_mode_q   <= i_mode;
            r_thresh_q <= i_thresh;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == S_IDLE)) begin
            r_col <= {COL_W{1'b0}};
            r_row <= {ROW_W{1'b0}};
        end else if (w_xfer) begin
            if (r_col == COL_LAST) begin
                r_col <= {COL_W{1'b0}};
                if (r_row == ROW_LAST) begin
                    r_row <= {ROW_W{1'b0}};
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Line buffers: shift the column down one line on every accepted pixel.
    always_ff @(posedge i_clk) begin
        if (w_xfer) begin
            r_lb1[r_col] <= w_col_mid;
            r_lb0[r_col] <= s_in.data;
        end
    end

    // 3x3 window column shift register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top0 <= {PIX_W{1'b0}};
            r_top1 <= {PIX_W{1'b0}};
            r_mid0 <= {PIX_W{1'b0}};
            r_mid1 <= {PIX_W{1'b0}};
            r_bot0 <= {PIX_W{1'b0}};
            r_bot1 <= {PIX_W{1'b0}};
        end else if (w_xfer) begin
            r_top0 <= r_top1;
            r_top1 <= w_col_top;
            r_mid0 <= r_mid1;
            r_mid1 <= w_col_mid;
            r_bot0 <= r_bot1;
            r_bot1 <= s_in.data;
        end
    end

    // Per-mode result for the pixel being accepted.
    always_comb begin
        w_result  = {PIX_W{1'b0}};
        w_has_out = 1'b0;
        case (r_mode_q)
            2'b00: begin
                w_result  = s_in.data;
                w_has_out = 1'b1;
            end
            2'b01: begin
                w_result  = ~s_in.data;
                w_has_out = 1'b1;
            end
            2'b10: begin
                w_result  = gauss3x3(r_top0, r_top1, w_col_top,
                                     r_mid0, r_mid1, w_col_mid,
                                     r_bot0, r_bot1, s_in.data);
                w_has_out = w_win_ok;
            end
            2'b11: begin
                if (s_in.data >= r_thresh_q) begin
                    w_result = {PIX_W{1'b1}};
                end else begin
                    w_result = {PIX_W{1'b0}};
                end
                w_has_out = 1'b1;
            end
            default: begin
                w_result  = {PIX_W{1'b0}};
                w_has_out = 1'b0;
            end
        endcase
    end

    // Output register: load on a producing transfer, empty when drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid_out <= 1'b0;
            r_pixel_out <= {PIX_W{1'b0}};
        end else if (w_xfer && w_has_out) begin
            r_valid_out <= 1'b1;
            r_pixel_out <= w_result;
        end else if (r_valid_out && m_out.ready) begin
            r_valid_out <= 1'b0;
        end
    end

    // Registered status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_flush_done;
        end
    end
endmodule
